// File: rtl/processor_stage2_if.sv
// Bus between fetch, the processor_stage2 decode/issue stage and downstream execute.
// The master modport is the environment side; the slave modport is the stage itself.
interface processor_stage2_if #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
);
  logic                 stall;
  logic                 resume;
  logic                 no_operation_in;
  logic [ADDR_SIZE-1:0] ip_in;
  logic [ADDR_SIZE-1:0] ip_plus_one_in;
  logic [WORD_SIZE-1:0] code_word;
  logic                 fetch_hold;
  logic                 call_performed;
  logic [WORD_SIZE-1:0] ip_to_call;
  logic                 no_operation_out;
  logic [3:0]           opcode_out;
  logic [2:0]           reg0_out;
  logic [2:0]           reg1_out;
  logic [WORD_SIZE-1:0] imm_out;
  logic [ADDR_SIZE-1:0] ip_out;
  logic [ADDR_SIZE-1:0] link_out;
  logic                 halted;
  logic [15:0]          instr_count;
  logic [15:0]          bubble_count;

  modport master (
    output stall, resume, no_operation_in, ip_in, ip_plus_one_in, code_word,
    input  fetch_hold, call_performed, ip_to_call, no_operation_out, opcode_out,
           reg0_out, reg1_out, imm_out, ip_out, link_out, halted,
           instr_count, bubble_count
  );

  modport slave (
    input  stall, resume, no_operation_in, ip_in, ip_plus_one_in, code_word,
    output fetch_hold, call_performed, ip_to_call, no_operation_out, opcode_out,
           reg0_out, reg1_out, imm_out, ip_out, link_out, halted,
           instr_count, bubble_count
  );
endinterface

// File: rtl/processor_stage2.sv
// Decode/issue stage with a one-entry skid buffer, RUN/HALT control and call redirect.
// Optional saturating perf counters are enabled by defining DECODE_PERF_COUNTERS_EN.
module processor_stage2 #(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18
) (
  input logic                 clock,
  input logic                 reset,
  processor_stage2_if.slave   bus
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic                 r_skid_valid;
  logic [WORD_SIZE-1:0] r_skid_word;
  logic [ADDR_SIZE-1:0] r_skid_ip;
  logic [ADDR_SIZE-1:0] r_skid_ip1;

  logic                 r_no_op;
  logic [3:0]           r_opcode;
  logic [2:0]           r_reg0;
  logic [2:0]           r_reg1;
  logic [WORD_SIZE-1:0] r_imm;
  logic [ADDR_SIZE-1:0] r_ip;
  logic [ADDR_SIZE-1:0] r_link;

  logic                 w_valid;
  logic [WORD_SIZE-1:0] w_word;
  logic [ADDR_SIZE-1:0] w_ip;
  logic [ADDR_SIZE-1:0] w_ip1;
  logic [3:0]           w_opcode;
  logic                 w_issue;
  logic                 w_is_halt;
  logic                 w_is_call;
  logic                 w_emit_instr;
  logic                 w_skid_load;
  logic [WORD_SIZE-1:0] w_imm;

  // A held skid entry always wins over the live fetch slot.
  assign w_valid   = r_skid_valid | ~bus.no_operation_in;
  assign w_word    = r_skid_valid ? r_skid_word : bus.code_word;
  assign w_ip      = r_skid_valid ? r_skid_ip   : bus.ip_in;
  assign w_ip1     = r_skid_valid ? r_skid_ip1  : bus.ip_plus_one_in;
  assign w_opcode  = w_word[17:14];
  assign w_issue   = w_valid & ~bus.stall & (r_state == ST_RUN);
  assign w_is_halt = (w_opcode == 4'hE);
  assign w_is_call = (w_opcode == 4'hC) | (w_opcode == 4'hF);

  assign w_emit_instr = w_issue & ~w_is_halt;
  assign w_skid_load  = bus.stall & ~bus.no_operation_in & ~r_skid_valid;

  assign bus.fetch_hold     = bus.stall | (r_state == ST_HALT) | (w_issue & w_is_halt);
  assign bus.call_performed = w_issue & w_is_call;
  assign bus.ip_to_call     = {{(WORD_SIZE-14){1'b0}}, w_word[13:0]};

  always_comb begin
    // NOTE: every always_comb target gets a default first so no path can infer a latch.
    w_imm = {{(WORD_SIZE-8){w_word[7]}}, w_word[7:0]};
    if (w_is_call) w_imm = {{(WORD_SIZE-14){1'b0}}, w_word[13:0]};
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN:  if (w_issue && w_is_halt) w_state_next = ST_HALT;
      ST_HALT: if (bus.resume)           w_state_next = ST_RUN;
      default: w_state_next = ST_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= ST_RUN;
      r_skid_valid <= 1'b0;
      r_no_op      <= 1'b1;
      r_opcode     <= '0;
      r_reg0       <= '0;
      r_reg1       <= '0;
      r_imm        <= '0;
      r_ip         <= '0;
      r_link       <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_skid_load)
        r_skid_valid <= 1'b1;
      else if (!bus.stall && r_state == ST_RUN)
        r_skid_valid <= 1'b0;
      if (!bus.stall) begin
        r_no_op <= ~w_emit_instr;
        if (w_emit_instr) begin
          r_opcode <= w_opcode;
          r_reg0   <= w_word[13:11];
          r_reg1   <= w_word[10:8];
          r_imm    <= w_imm;
          r_ip     <= w_ip;
          r_link   <= w_ip1;
        end
      end
    end
  end

  // NOTE: the skid payload needs no reset; r_skid_valid alone decides whether it is used.
  always_ff @(posedge clock) begin
    if (w_skid_load) begin
      r_skid_word <= bus.code_word;
      r_skid_ip   <= bus.ip_in;
      r_skid_ip1  <= bus.ip_plus_one_in;
    end
  end

  assign bus.no_operation_out = r_no_op;
  assign bus.opcode_out       = r_opcode;
  assign bus.reg0_out         = r_reg0;
  assign bus.reg1_out         = r_reg1;
  assign bus.imm_out          = r_imm;
  assign bus.ip_out           = r_ip;
  assign bus.link_out         = r_link;
  assign bus.halted           = (r_state == ST_HALT);

`ifdef DECODE_PERF_COUNTERS_EN
  logic [15:0] r_instr_count;
  logic [15:0] r_bubble_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_instr_count  <= '0;
      r_bubble_count <= '0;
    end else begin
      if (w_emit_instr && r_instr_count != 16'hFFFF)
        r_instr_count <= r_instr_count + 16'd1;
      if (!bus.stall && !w_emit_instr && r_bubble_count != 16'hFFFF)
        r_bubble_count <= r_bubble_count + 16'd1;
    end
  end

  assign bus.instr_count  = r_instr_count;
  assign bus.bubble_count = r_bubble_count;
`else
  assign bus.instr_count  = '0;
  assign bus.bubble_count = '0;
`endif

endmodule

// File: doc/processor_stage2.md
PROCESSOR_STAGE2 -- requirements
Module: processor_stage2

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 18, the instruction address width.
REQ-002 SHALL have parameter WORD_SIZE, default 18, the instruction and data word width.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-low; reset==0 at a rising edge resets the block.
REQ-005 SHALL have port stall, input, 1 bit: downstream cannot accept an instruction this cycle.
REQ-006 SHALL have port resume, input, 1 bit: leave HALT state.
REQ-007 SHALL have ports no_operation_in (1), ip_in (ADDR_SIZE) and ip_plus_one_in (ADDR_SIZE), inputs: the fetch-stage slot.
REQ-008 SHALL have port code_word, input, WORD_SIZE: instruction word from code memory for ip_in.
REQ-009 SHALL have port fetch_hold, output, 1 bit, combinational: drives the fetch stage's no_operation.
REQ-010 SHALL have ports call_performed (1) and ip_to_call (WORD_SIZE), outputs, combinational: redirect to fetch.
REQ-011 SHALL have registered outputs no_operation_out (1), opcode_out (4), reg0_out (3), reg1_out (3), imm_out (WORD_SIZE), ip_out (ADDR_SIZE), link_out (ADDR_SIZE), halted (1).
REQ-012 SHALL have outputs instr_count (16) and bubble_count (16).

Function
REQ-013 SHALL decode fields: opcode=[17:14], reg0=[13:11], reg1=[10:8], imm8=[7:0], imm14=[13:0].
REQ-014 SHALL set imm_out to zero-extended imm14 for opcodes C and F, else sign-extended imm8.
REQ-015 SHALL treat opcode F (JMP) and C (CALL), when issued, as call_performed=1 with ip_to_call=zero-extended imm14 in the same cycle.
REQ-016 SHALL set link_out to the issued instruction's ip_plus_one for every issued instruction.
REQ-017 SHALL issue an instruction when valid (no_operation_in==0 or skid full), stall==0 and state==RUN; the issued instruction appears on outputs one cycle later with no_operation_out=0.
REQ-018 SHALL emit a bubble (no_operation_out=1, other outputs unchanged) when stall==0 and nothing is issued.
REQ-019 SHALL hold all registered outputs unchanged while stall==1.
REQ-020 SHALL capture a valid input arriving while stall==1 into a one-entry skid buffer (code_word, ip_in, ip_plus_one_in).
REQ-021 SHALL issue from the skid buffer in preference to inputs on the first cycle stall==0, then clear it.
REQ-022 SHALL ignore a valid input while the skid is full.
REQ-023 SHALL assert fetch_hold = stall OR state==HALT OR (HALT opcode issued this cycle).
REQ-024 SHALL implement states RUN and HALT: issuing opcode E moves RUN->HALT, emits a bubble; in HALT, resume==1 moves to RUN on the next edge; halted=1 exactly in HALT.
REQ-025 SHALL never assert call_performed while stall==1 or in HALT.
REQ-026 SHALL give resume priority over nothing else; resume in RUN has no effect.

Reset
REQ-027 SHALL on reset==0 set state RUN, skid empty, no_operation_out=1, halted=0, opcode_out, reg0_out, reg1_out, imm_out, ip_out, link_out and both counters to 0.
REQ-028 SHALL discard skid contents and HALT state on reset mid-operation.

Configuration
REQ-029 SHALL, with macro DECODE_PERF_COUNTERS_EN defined, increment instr_count per issued non-HALT instruction and bubble_count per emitted bubble, each saturating at 16'hFFFF.
REQ-030 SHALL, without DECODE_PERF_COUNTERS_EN, drive instr_count and bubble_count constant 0 with no counter logic.

Verification
REQ-031 SHALL cover: code_word=18'h0A305 (opcode 2, reg0=4, reg1=3, imm8=05), ip_in=10 -> next cycle opcode_out=2, reg0_out=4, reg1_out=3, imm_out=5, link_out=11.
REQ-032 SHALL cover: JMP imm14=0x0123 at ip 7 -> same cycle call_performed=1, ip_to_call=0x0123; opcode_out=F next cycle.
REQ-033 SHALL cover: stall=1 for 3 cycles with valid input ip 20 -> outputs frozen, fetch_hold=1; first cycle stall=0 issues ip 20 from skid; no instruction lost or duplicated.
REQ-034 SHALL cover: HALT at ip 30 -> fetch_hold=1, halted=1 next cycle, bubbles emitted; resume pulse -> halted=0 and fetch_hold=0 one cycle later.
REQ-035 SHALL cover: reset=0 while skid full and in HALT -> all REQ-027 values next cycle, no later issue of skid entry.
REQ-036 SHALL cover: with DECODE_PERF_COUNTERS_EN, 5 issued instructions and 2 bubbles -> instr_count=5, bubble_count=2; preset to 0xFFFF stays 0xFFFF.
